// File: rtl/ins_fetcher_pkg.sv
// Shared constants for the instruction fetcher.
// Contents:
//   JAL           RV32 opcode, the only one the fetcher inspects (for JAL prediction)
//   fetch_state_e 2-bit fetch FSM encoding
package ins_fetcher_pkg;

  localparam logic [6:0] JAL = 7'b1101111;

  typedef enum logic [1:0] {
    StFetch = 2'd0,  // issue a request for fetch_pc
    StWait  = 2'd1,  // request outstanding
    StHold  = 2'd2,  // instruction presented to the decoder
    StDrop  = 2'd3   // request outstanding, but its response will be discarded
  } fetch_state_e;

endpackage

// File: rtl/ins_fetcher_next_pc.sv
// Combinational next fetch address.
// Optional feature: `define PREDICT_JAL_EN to follow JAL targets at fetch time.
// Ports:
//   addr    in  32  address the instruction word was fetched from
//   data    in  32  the fetched instruction word
//   next_pc out 32  address of the next instruction to fetch
module ins_fetcher_next_pc
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned INS_BYTES = 4
) (
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] next_pc
);

`ifdef PREDICT_JAL_EN
  logic [31:0] jal_off;

  // J-type immediate: imm[20|10:1|11|19:12] in data[31:12], bit 0 implied zero.
  assign jal_off = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};

  always_comb begin
    next_pc = addr + 32'(INS_BYTES);
    if (data[6:0] == JAL) begin
      next_pc = addr + jal_off;
    end
  end
`else
  logic unused_data;

  // Without prediction the decoder redirects JAL via dec_clear.
  assign unused_data = ^data;
  assign next_pc     = addr + 32'(INS_BYTES);
`endif

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: owns the fetch PC, issues one 32-bit read at a time to the memory
// controller and presents {ins, pc, ins_ready} to the decoder. Honours decoder stall and
// clear/redirect. Optional feature: `define PREDICT_JAL_EN (see ins_fetcher_next_pc).
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low freezes all state)
//   mem_req_valid/mem_req_addr   read request, held until mem_resp_valid
//   mem_resp_valid/mem_resp_data one-cycle response for mem_req_addr
//   dec_stall, dec_clear, dec_new_addr  decoder back-pressure and redirect
//   ins_ready/ins/pc             presented instruction
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned INS_BYTES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        dec_stall,
  input  logic        dec_clear,
  input  logic [31:0] dec_new_addr,
  output logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         req_valid_q, req_valid_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         ins_ready_q, ins_ready_d;
  logic [31:0]  ins_q, ins_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  next_pc;

  ins_fetcher_next_pc #(
    .INS_BYTES(INS_BYTES)
  ) u_next_pc (
    .addr   (req_addr_q),
    .data   (mem_resp_data),
    .next_pc(next_pc)
  );

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    ins_ready_d = ins_ready_q;
    ins_d       = ins_q;
    pc_d        = pc_q;

    if (dec_clear) begin
      fetch_pc_d  = dec_new_addr;
      ins_ready_d = 1'b0;
      unique case (state_q)
        StWait: begin
          if (mem_resp_valid) begin
            req_valid_d = 1'b0;
            state_d     = StFetch;
          end else begin
            state_d = StDrop;
          end
        end
        StDrop: begin
          // A response landing with the clear still retires the orphan, else we would wait forever.
          if (mem_resp_valid) begin
            req_valid_d = 1'b0;
            state_d     = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          req_valid_d = 1'b1;
          req_addr_d  = fetch_pc_q;
          state_d     = StWait;
        end
        StWait: begin
          if (mem_resp_valid) begin
            req_valid_d = 1'b0;
            ins_d       = mem_resp_data;
            pc_d        = req_addr_q;
            ins_ready_d = 1'b1;
            fetch_pc_d  = next_pc;
            state_d     = StHold;
          end
        end
        StHold: begin
          if (ins_ready_q && !dec_stall) begin
            ins_ready_d = 1'b0;
            state_d     = StFetch;
          end
        end
        StDrop: begin
          if (mem_resp_valid) begin
            req_valid_d = 1'b0;
            state_d     = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StFetch;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      ins_ready_q <= 1'b0;
      ins_q       <= '0;
      pc_q        <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      ins_ready_q <= ins_ready_d;
      ins_q       <= ins_d;
      pc_q        <= pc_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign ins_ready     = ins_ready_q;
  assign ins           = ins_q;
  assign pc            = pc_q;

endmodule

// File: tb/tb_ins_fetcher.sv
module tb_ins_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        dec_stall;
  logic        dec_clear;
  logic [31:0] dec_new_addr;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] pc;

  int n_total = 0;
  int n_pass  = 0;

`ifdef PREDICT_JAL_EN
  localparam logic [31:0] JalNext = 32'h0000_0050;
`else
  localparam logic [31:0] JalNext = 32'h0000_0044;
`endif

  ins_fetcher dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .dec_stall     (dec_stall),
    .dec_clear     (dec_clear),
    .dec_new_addr  (dec_new_addr),
    .ins_ready     (ins_ready),
    .ins           (ins),
    .pc            (pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        stall;
    logic        clear;
    logic [31:0] new_addr;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ir;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic resp, logic [31:0] data, logic stall,
                              logic clear, logic [31:0] new_addr, logic e_rv,
                              logic [31:0] e_ra, logic e_ir, logic [31:0] e_ins,
                              logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.resp = resp; v.data = data; v.stall = stall; v.clear = clear;
    v.new_addr = new_addr; v.e_rv = e_rv; v.e_ra = e_ra; v.e_ir = e_ir;
    v.e_ins = e_ins; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    dec_stall = 1'b0; dec_clear = 1'b0; dec_new_addr = '0;
  endtask

  task automatic check_all(input string tag, input logic rv, input logic [31:0] ra,
                           input logic ir, input logic [31:0] ei, input logic [31:0] ep);
    check({tag, ".req_valid"}, 32'(mem_req_valid), 32'(rv));
    check({tag, ".req_addr"}, mem_req_addr, ra);
    check({tag, ".ins_ready"}, 32'(ins_ready), 32'(ir));
    check({tag, ".ins"}, ins, ei);
    check({tag, ".pc"}, pc, ep);
  endtask

  initial begin
    //        rdy resp data           stl clr new_addr       rv ra             ir ins            pc
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 1, 32'h13,        0, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    // stall 5 cycles; a stray response in HOLD is ignored
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    vecs.push_back(mk(1, 1, 32'hBAD,       1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h13,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         0, 32'h13,        32'h0));
    vecs.push_back(mk(1, 1, 32'h00100093,  0, 0, 32'h0,         0, 32'h4,         1, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         0, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h00100093,  32'h4));
    // clear in WAIT -> DROP, stale response discarded, refetch 0x100
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h100,       1, 32'h8,         0, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 1, 32'hDEADBEEF,  0, 0, 32'h0,         0, 32'h8,         0, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       0, 32'h00100093,  32'h4));
    // clear coincident with response
    vecs.push_back(mk(1, 1, 32'h13,        0, 1, 32'h200,       0, 32'h100,       0, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       0, 32'h00100093,  32'h4));
    // rdy_in low freezes even with a response present
    vecs.push_back(mk(0, 1, 32'h55,        0, 0, 32'h0,         1, 32'h200,       0, 32'h00100093,  32'h4));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       0, 32'h00100093,  32'h4));
    vecs.push_back(mk(1, 1, 32'h33,        0, 0, 32'h0,         0, 32'h200,       1, 32'h33,        32'h200));
    // clear beats stall in HOLD
    vecs.push_back(mk(1, 0, 32'h0,         1, 1, 32'h40,        0, 32'h200,       0, 32'h33,        32'h200));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h33,        32'h200));
    // JAL +16 at 0x40
    vecs.push_back(mk(1, 1, 32'h0100006F,  0, 0, 32'h0,         0, 32'h40,        1, 32'h0100006F,  32'h40));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h40,        0, 32'h0100006F,  32'h40));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, JalNext,       0, 32'h0100006F,  32'h40));
    // address wrap at the top of memory
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'hFFFFFFFC,  1, JalNext,       0, 32'h0100006F,  32'h40));
    vecs.push_back(mk(1, 1, 32'h0,         0, 0, 32'h0,         0, JalNext,       0, 32'h0100006F,  32'h40));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0100006F,  32'h40));
    vecs.push_back(mk(1, 1, 32'h13,        0, 0, 32'h0,         0, 32'hFFFFFFFC,  1, 32'h13,        32'hFFFFFFFC));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFFFFFC,  0, 32'h13,        32'hFFFFFFFC));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h13,        32'hFFFFFFFC));

    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      rdy_in         = vecs[i].rdy;
      mem_resp_valid = vecs[i].resp;
      mem_resp_data  = vecs[i].data;
      dec_stall      = vecs[i].stall;
      dec_clear      = vecs[i].clear;
      dec_new_addr   = vecs[i].new_addr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_ra, vecs[i].e_ir,
                vecs[i].e_ins, vecs[i].e_pc);
    end

    // Reset wins over rdy_in=0 while a request is outstanding.
    idle_inputs();
    rdy_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    check_all("rst_over_rdy", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Bounded wait for the post-reset request, then a 2-cycle-latency response.
    begin
      int cycles = 0;
      while (!mem_req_valid && cycles < 10) begin
        tick();
        cycles++;
      end
      check("req_after_reset", 32'(mem_req_valid), 32'h1);
      check("req_addr_after_reset", mem_req_addr, 32'h0);
    end
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0513;
    tick();
    mem_resp_valid = 1'b0;
    check_all("late_resp", 1'b0, 32'h0, 1'b1, 32'h0000_0513, 32'h0);
    tick();
    check("consume_no_req_yet", 32'(mem_req_valid), 32'h0);
    tick();
    check("consume_req_m2", 32'(mem_req_valid), 32'h1);
    check("consume_req_addr", mem_req_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

endmodule
